// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory link and IF/ID outputs.
interface if_fetch_stage_if #(
    parameter int PC_LENGTH   = 32,
    parameter int INST_LENGTH = 32
);
    logic                   stall;
    logic                   flush;
    logic                   br_taken;
    logic [PC_LENGTH-1:0]   br_target;
    logic [PC_LENGTH-1:0]   PC;
    logic [INST_LENGTH-1:0] inst_in;
    logic [PC_LENGTH-1:0]   id_pc;
    logic [PC_LENGTH-1:0]   id_pc4;
    logic [INST_LENGTH-1:0] id_inst;
    logic                   id_valid;
    logic                   misalign;
    logic                   fetch_halt;

    // The fetch stage itself is the master; the surrounding pipeline/memory is the slave.
    modport master (
        input  stall, flush, br_taken, br_target, inst_in,
        output PC, id_pc, id_pc4, id_inst, id_valid, misalign, fetch_halt
    );

    modport slave (
        output stall, flush, br_taken, br_target, inst_in,
        input  PC, id_pc, id_pc4, id_inst, id_valid, misalign, fetch_halt
    );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// Generic pipeline register holding pc/pc4/inst/valid with hold and bubble controls.
module if_id_reg #(
    parameter int                     PC_LENGTH   = 32,
    parameter int                     INST_LENGTH = 32,
    parameter logic [INST_LENGTH-1:0] NOP_INST    = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_hold,
    input  logic                   i_bubble,
    input  logic [PC_LENGTH-1:0]   i_pc,
    input  logic [PC_LENGTH-1:0]   i_pc4,
    input  logic [INST_LENGTH-1:0] i_inst,
    output logic [PC_LENGTH-1:0]   o_pc,
    output logic [PC_LENGTH-1:0]   o_pc4,
    output logic [INST_LENGTH-1:0] o_inst,
    output logic                   o_valid
);

    logic [PC_LENGTH-1:0]   r_pc;
    logic [PC_LENGTH-1:0]   r_pc4;
    logic [INST_LENGTH-1:0] r_inst;
    logic                   r_valid;

    // Bubble wins over hold so a flush during a stall still squashes the held word.
    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, range check, BOOT/RUN/HALT FSM and IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                     PC_LENGTH   = 32,
    parameter int                     INST_LENGTH = 32,
    parameter logic [PC_LENGTH-1:0]   RESET_PC    = if_fetch_stage_pkg::RESET_PC,
    parameter int                     IMEM_WORDS  = 18,
    parameter logic [INST_LENGTH-1:0] NOP_INST    = if_fetch_stage_pkg::NOP_INST
) (
    input logic              clk,
    input logic              rst,
    if_fetch_stage_if.master bus
);

    localparam logic [PC_LENGTH:0] IMEM_BYTES = (PC_LENGTH+1)'(IMEM_WORDS) << 2;

    fetch_state_e         r_state;
    logic [PC_LENGTH-1:0] r_pc;
    logic                 r_misalign;

    logic [PC_LENGTH-1:0] w_pcPlus4;
    logic [PC_LENGTH-1:0] w_brAligned;
    logic                 w_pcInRange;
    logic                 w_tgtInRange;
    logic                 w_hold;
    logic                 w_bubble;

    assign w_pcPlus4    = r_pc + PC_LENGTH'(4);
    assign w_brAligned  = {bus.br_target[PC_LENGTH-1:2], 2'b00};
    assign w_pcInRange  = {1'b0, r_pc} < IMEM_BYTES;
    assign w_tgtInRange = {1'b0, w_brAligned} < IMEM_BYTES;

    // IF/ID only captures in RUN on a clean, in-range, unstalled, unflushed cycle.
    always_comb begin
        w_hold   = 1'b0;
        w_bubble = 1'b1;
        if (r_state == RUN && !bus.br_taken) begin
            if (bus.stall) begin
                w_hold   = !bus.flush;
                w_bubble = bus.flush;
            end else if (w_pcInRange && !bus.flush) begin
                w_bubble = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= BOOT;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (bus.br_taken) begin
                        r_pc       <= w_brAligned;
                        r_misalign <= |bus.br_target[1:0];
                    end else if (bus.stall) begin
                        r_pc <= r_pc;
                    end else if (!w_pcInRange) begin
                        r_state <= HALT;
                    end else begin
                        r_pc <= w_pcPlus4;
                    end
                end
                HALT: begin
                    // Only a redirect that lands inside the program can wake the stage.
                    if (bus.br_taken && w_tgtInRange) begin
                        r_pc       <= w_brAligned;
                        r_misalign <= |bus.br_target[1:0];
                        r_state    <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    if_id_reg #(
        .PC_LENGTH  (PC_LENGTH),
        .INST_LENGTH(INST_LENGTH),
        .NOP_INST   (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_hold),
        .i_bubble(w_bubble),
        .i_pc    (r_pc),
        .i_pc4   (w_pcPlus4),
        .i_inst  (bus.inst_in),
        .o_pc    (bus.id_pc),
        .o_pc4   (bus.id_pc4),
        .o_inst  (bus.id_inst),
        .o_valid (bus.id_valid)
    );

    assign bus.PC         = r_pc;
    assign bus.misalign   = r_misalign;
    assign bus.fetch_halt = (r_state == HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random traffic against a behavioural model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int          WORDS      = 18;
    localparam logic [31:0] LIMIT      = 32'(WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem [0:31];

    int checks = 0;
    int errors = 0;

    // Behavioural model of what IF/ID and the PC should look like after each edge.
    logic [31:0] mPc, mIdPc, mIdPc4, mIdInst;
    logic        mValid, mMis, mBoot, mHalt;

    if_fetch_stage_if #(.PC_LENGTH(32), .INST_LENGTH(32)) bus ();

    if_fetch_stage #(
        .PC_LENGTH  (32),
        .INST_LENGTH(32),
        .RESET_PC   (32'h0),
        .IMEM_WORDS (WORDS),
        .NOP_INST   (NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.inst_in = (bus.PC < LIMIT) ? imem[bus.PC[6:2]] : 32'hBAD0_BAD0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setBubble();
        mIdPc   = 32'h0;
        mIdPc4  = 32'h0;
        mIdInst = NOP;
        mValid  = 1'b0;
    endtask

    task automatic modelStep(input logic r, input logic s, input logic f, input logic b, input logic [31:0] t);
        logic [31:0] aligned;
        aligned = t & 32'hFFFF_FFFC;
        mMis    = 1'b0;
        if (r) begin
            mPc = 32'h0; mBoot = 1'b1; mHalt = 1'b0;
            setBubble();
        end else if (mBoot) begin
            mBoot = 1'b0;
            setBubble();
        end else if (mHalt) begin
            setBubble();
            if (b && aligned < LIMIT) begin
                mPc = aligned; mMis = (t[1:0] != 2'b00); mHalt = 1'b0;
            end
        end else if (b) begin
            mPc = aligned; mMis = (t[1:0] != 2'b00);
            setBubble();
        end else if (s) begin
            if (f) setBubble();
        end else if (mPc >= LIMIT) begin
            mHalt = 1'b1;
            setBubble();
        end else if (f) begin
            mPc = mPc + 32'd4;
            setBubble();
        end else begin
            mIdPc = mPc; mIdPc4 = mPc + 32'd4; mIdInst = imem[mPc[6:2]]; mValid = 1'b1;
            mPc = mPc + 32'd4;
        end
    endtask

    task automatic compareAll();
        checkOutput("PC", bus.PC, mPc);
        checkOutput("id_valid", 32'(bus.id_valid), 32'(mValid));
        checkOutput("id_inst", bus.id_inst, mIdInst);
        checkOutput("misalign", 32'(bus.misalign), 32'(mMis));
        checkOutput("fetch_halt", 32'(bus.fetch_halt), 32'(mHalt));
        if (mValid) begin
            checkOutput("id_pc", bus.id_pc, mIdPc);
            checkOutput("id_pc4", bus.id_pc4, mIdPc4);
        end
    endtask

    // Drive one cycle of inputs, advance the model and the DUT by one edge, then compare.
    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic b, input logic [31:0] t);
        rst           = r;
        bus.stall     = s;
        bus.flush     = f;
        bus.br_taken  = b;
        bus.br_target = t;
        modelStep(r, s, f, b, t);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = $urandom;
        imem[0] = 32'd11; imem[1] = 32'd22; imem[2] = 32'd33; imem[3] = 32'd44;
        mPc = 32'h0; mBoot = 1'b1; mHalt = 1'b0; mMis = 1'b0;
        setBubble();

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_inst", bus.id_inst, NOP);
        checkOutput("reset_pc", bus.PC, 32'h0);

        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("boot_bubble", 32'(bus.id_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("first_inst", bus.id_inst, 32'd11);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("second_inst", bus.id_inst, 32'd22);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("stall_pc", bus.PC, 32'h8);
        checkOutput("stall_hold", bus.id_inst, 32'd22);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("after_stall_a", bus.id_inst, 32'd33);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("after_stall_b", bus.id_inst, 32'd44);

        applyStimulus(0, 1, 0, 1, 32'h20);
        checkOutput("br_pc", bus.PC, 32'h20);
        checkOutput("br_bubble", 32'(bus.id_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("br_first_pc", bus.id_pc, 32'h20);

        applyStimulus(0, 0, 0, 1, 32'h22);
        checkOutput("mis_set", 32'(bus.misalign), 32'd1);
        checkOutput("mis_pc", bus.PC, 32'h20);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mis_clear", 32'(bus.misalign), 32'd0);

        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("halt_flag", 32'(bus.fetch_halt), 32'd1);
        checkOutput("halt_pc", bus.PC, 32'h48);
        applyStimulus(0, 0, 0, 1, 32'h100);
        checkOutput("halt_oob_br", 32'(bus.fetch_halt), 32'd1);
        applyStimulus(0, 0, 0, 1, 32'h0);
        checkOutput("resume_pc", bus.PC, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 32'h30);
        checkOutput("rst_mid_pc", bus.PC, 32'h0);
        checkOutput("rst_mid_valid", 32'(bus.id_valid), 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic        r, s, f, b;
            logic [31:0] t;
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h5F));
            applyStimulus(r, s, f, b, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
